// File: rtl/nock_execute.sv
// Nock opcode executor: fetches the formula cell referenced by a marked cell,
// evaluates opcode 1 (constant) or 4 (increment) and rewrites the marked cell in place.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 28
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef CELL_CELL
`define CELL_CELL 2'b00
`endif
`ifndef CELL_ATOM
`define CELL_ATOM 2'b01
`endif
`ifndef ATOM_CELL
`define ATOM_CELL 2'b10
`endif
`ifndef ATOM_ATOM
`define ATOM_ATOM 2'b11
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'h1
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'h2
`endif

module nock_execute (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          execute_start,
    input  logic [`MEMORY_ADDR_WIDTH-1:0] execute_address,
    input  logic [`TAG_WIDTH-1:0]         execute_tag,
    input  logic [`MEMORY_DATA_WIDTH-1:0] execute_data,
    input  logic                          mem_ready,
    input  logic [`MEMORY_DATA_WIDTH-1:0] read_data,
    output logic                          mem_execute,
    output logic [1:0]                    mem_func,
    output logic [`MEMORY_ADDR_WIDTH-1:0] address,
    output logic [`MEMORY_DATA_WIDTH-1:0] write_data,
    output logic                          execute_finished,
    output logic [3:0]                    execute_return_sys_func,
    output logic [3:0]                    execute_return_state,
    output logic [7:0]                    error
);
    localparam int AW = `MEMORY_ADDR_WIDTH;
    localparam int DW = `MEMORY_DATA_WIDTH;
    localparam int TW = `TAG_WIDTH;
    localparam int VW = (DW - TW) / 2;

    typedef enum logic [2:0] {
        IDLE, RD_REQ, RD_WAIT, DECODE, WR_REQ, WR_WAIT, DONE, HOLD
    } state_t;

    state_t          state;
    logic [AW-1:0]   cell_addr;
    logic [TW-1:0]   cell_tag;
    logic [DW-1:0]   cell_data;
    logic [DW-1:0]   form;

    logic [TW-1:0]   form_tag;
    logic [VW-1:0]   form_hed;
    logic [VW-1:0]   form_tel;
    logic [VW-1:0]   subject;
    logic [VW-1:0]   cell_tel;

    logic [7:0]      dec_err;
    logic [VW-1:0]   dec_result;
    logic            dec_atom;
    logic [TW-1:0]   new_tag;

    assign form_tag = form[DW-1 -: TW];
    assign form_hed = form[2*VW-1 -: VW];
    assign form_tel = form[VW-1:0];
    assign subject  = cell_data[2*VW-1 -: VW];
    assign cell_tel = cell_data[VW-1:0];

    always_comb begin
        dec_err    = 8'h00;
        dec_result = '0;
        dec_atom   = 1'b0;
        if (!((form_tag[1:0] == `ATOM_ATOM) || (form_tag[1:0] == `ATOM_CELL))) begin
            dec_err = 8'h02;
        end else if (form_hed == VW'(1)) begin
            dec_result = form_tel;
            dec_atom   = (form_tag[1:0] == `ATOM_ATOM) || (form_tag[1:0] == `CELL_ATOM);
        end else if (form_hed == VW'(4)) begin
            if (!((cell_tag[1:0] == `ATOM_ATOM) || (cell_tag[1:0] == `ATOM_CELL))) begin
                dec_err = 8'h02;
            end else if (&subject) begin
                dec_err = 8'h03;
            end else begin
                dec_result = subject + VW'(1);
                dec_atom   = 1'b1;
            end
        end else begin
            dec_err = 8'h01;
        end
    end

    // Execute mark and visit flags are cleared so traversal sees a fresh cell.
    assign new_tag = (cell_tag & TW'(8'h70)) |
                     TW'(dec_atom ? `ATOM_ATOM : `CELL_ATOM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state                   <= IDLE;
            cell_addr               <= '0;
            cell_tag                <= '0;
            cell_data               <= '0;
            form                    <= '0;
            mem_execute             <= 1'b0;
            mem_func                <= 2'h0;
            address                 <= '0;
            write_data              <= '0;
            execute_finished        <= 1'b0;
            execute_return_sys_func <= 4'h0;
            execute_return_state    <= 4'h0;
            error                   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (execute_start) begin
                        cell_addr               <= execute_address;
                        cell_tag                <= execute_tag;
                        cell_data               <= execute_data;
                        address                 <= execute_data[AW-1:0];
                        mem_func                <= `GET_CONTENTS;
                        mem_execute             <= 1'b1;
                        error                   <= 8'h00;
                        execute_return_sys_func <= 4'h0;
                        execute_return_state    <= 4'h0;
                        state                   <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    mem_execute <= 1'b0;
                    state       <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (mem_ready) begin
                        form  <= read_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (dec_err != 8'h00) begin
                        error                   <= dec_err;
                        execute_return_sys_func <= 4'h3;
                        execute_return_state    <= 4'hF;
                        execute_finished        <= 1'b1;
                        state                   <= DONE;
                    end else begin
                        address     <= cell_addr;
                        write_data  <= {new_tag, dec_result, VW'(0)};
                        mem_func    <= `SET_CONTENTS;
                        mem_execute <= 1'b1;
                        state       <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    mem_execute <= 1'b0;
                    state       <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (mem_ready) begin
                        execute_return_sys_func <= 4'h0;
                        execute_return_state    <= 4'h0;
                        execute_finished        <= 1'b1;
                        state                   <= DONE;
                    end
                end
                DONE: begin
                    execute_finished <= 1'b0;
                    state            <= HOLD;
                end
                HOLD: begin
                    if (!execute_start) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^cell_tel;
endmodule

// File: tb/tb_nock_execute.sv
// Directed bench for nock_execute with a small behavioural memory responder.
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 28
`endif
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef GET_CONTENTS
`define GET_CONTENTS 2'h1
`endif
`ifndef SET_CONTENTS
`define SET_CONTENTS 2'h2
`endif

module tb_nock_execute;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        execute_start = 1'b0;
    logic [27:0] execute_address = '0;
    logic [7:0]  execute_tag = '0;
    logic [63:0] execute_data = '0;
    logic        mem_ready = 1'b0;
    logic [63:0] read_data = '0;
    logic        mem_execute;
    logic [1:0]  mem_func;
    logic [27:0] address;
    logic [63:0] write_data;
    logic        execute_finished;
    logic [3:0]  execute_return_sys_func;
    logic [3:0]  execute_return_state;
    logic [7:0]  error;

    nock_execute dut (
        .clk(clk), .rst(rst), .execute_start(execute_start),
        .execute_address(execute_address), .execute_tag(execute_tag),
        .execute_data(execute_data), .mem_ready(mem_ready), .read_data(read_data),
        .mem_execute(mem_execute), .mem_func(mem_func), .address(address),
        .write_data(write_data), .execute_finished(execute_finished),
        .execute_return_sys_func(execute_return_sys_func),
        .execute_return_state(execute_return_state), .error(error)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:15];
    int          lat = 1;
    bit          no_resp = 0;
    int          reads = 0;
    int          writes = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          lat_cycles = 0;
    int          fin_count = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: sees a request #1 after the edge, answers lat edges later.
    initial begin
        logic [1:0]  f;
        logic [27:0] a;
        logic [63:0] w;
        forever begin
            @(posedge clk); #1;
            if (mem_execute && !rst) begin
                f = mem_func; a = address; w = write_data;
                if (f == `GET_CONTENTS) reads++;
                if (f == `SET_CONTENTS) begin writes++; mem[a[3:0]] = w; end
                if (!no_resp) begin
                    repeat (lat) @(posedge clk);
                    #1;
                    mem_ready = 1'b1;
                    read_data = (f == `GET_CONTENTS) ? mem[a[3:0]] : 64'h0;
                    @(posedge clk); #1;
                    mem_ready = 1'b0;
                    read_data = 64'h0;
                end
            end
        end
    end

    always @(posedge clk) if (execute_finished) fin_count++;

    // Drives start and waits for finished; pulse=1 drops start right after acceptance.
    task automatic run(input logic [7:0] tag, input logic [27:0] hed, input logic [27:0] tel,
                       input bit pulse);
        reads = 0; writes = 0; lat_cycles = 0;
        @(posedge clk); #1;
        execute_address = 28'd5;
        execute_tag     = tag;
        execute_data    = {tag, hed, tel};
        execute_start   = 1'b1;
        do begin
            @(posedge clk); #1;
            lat_cycles++;
            if (pulse) execute_start = 1'b0;
        end while (!execute_finished && lat_cycles < 200);
        check("finished_timeout", {63'h0, execute_finished}, 64'h1);
        @(posedge clk); #1;
        check("finished_one_cycle", {63'h0, execute_finished}, 64'h0);
        execute_start = 1'b0;
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 64'h0;
        repeat (3) @(posedge clk); #1;
        check("reset_mem_execute", {63'h0, mem_execute}, 64'h0);
        check("reset_outputs", {address, mem_func, execute_finished, error,
                                execute_return_sys_func, execute_return_state}, 64'h0);
        check("reset_write_data", write_data, 64'h0);
        rst = 1'b0;

        // Opcode 1, atom result; tag 0xDE -> rewritten tag 0x53.
        mem[9] = {8'h03, 28'd1, 28'd42};
        mem[5] = 64'h0;
        run(8'hDE, 28'd7, 28'd9, 0);
        // Accept edge + RD_REQ + RD_WAIT + DECODE + WR_REQ + WR_WAIT edges with 1-cycle memory.
        check("op1_latency", 64'(lat_cycles), 64'd6);
        check("op1_mem5", mem[5], {8'h53, 28'd42, 28'd0});
        check("op1_reads", 64'(reads), 64'd1);
        check("op1_writes", 64'(writes), 64'd1);
        check("op1_ret", {56'h0, execute_return_sys_func, execute_return_state}, 64'h00);
        check("op1_err", {56'h0, error}, 64'h0);

        // Opcode 4, subject 7 -> 8.
        mem[9] = {8'h03, 28'd4, 28'd0};
        run(8'hDE, 28'd7, 28'd9, 0);
        check("op4_mem5", mem[5], {8'h53, 28'd8, 28'd0});
        check("op4_ret", {56'h0, execute_return_sys_func, execute_return_state}, 64'h00);

        // Unknown opcode 6.
        mem[5] = 64'h1234;
        mem[9] = {8'h03, 28'd6, 28'd0};
        run(8'hDE, 28'd7, 28'd9, 0);
        check("op6_err", {56'h0, error}, 64'h01);
        check("op6_ret", {56'h0, execute_return_sys_func, execute_return_state}, 64'h3F);
        check("op6_reads", 64'(reads), 64'd1);
        check("op6_no_write", 64'(writes), 64'd0);
        check("op6_mem5_kept", mem[5], 64'h1234);
        repeat (3) @(posedge clk); #1;
        check("op6_err_hold", {56'h0, error}, 64'h01);

        // Opcode 4 on an all-ones subject.
        mem[9] = {8'h03, 28'd4, 28'd0};
        run(8'h82, 28'hFFFFFFF, 28'd9, 0);
        check("op4_ovf_err", {56'h0, error}, 64'h03);
        check("op4_ovf_no_write", 64'(writes), 64'd0);

        // Opcode 4 on a cell subject.
        run(8'h80, 28'd3, 28'd9, 0);
        check("op4_cell_err", {56'h0, error}, 64'h02);
        check("op4_cell_no_write", 64'(writes), 64'd0);

        // Formula whose hed is a cell.
        mem[9] = {8'h00, 28'd1, 28'd5};
        run(8'h82, 28'd3, 28'd9, 0);
        check("fcell_err", {56'h0, error}, 64'h02);

        // Opcode 1 with cell tail, slow memory, start dropped after accept.
        lat = 3;
        mem[9] = {8'h02, 28'd1, 28'd13};
        run(8'h82, 28'd3, 28'd9, 1);
        check("op1_cell_mem5", mem[5], {8'h01, 28'd13, 28'd0});
        check("op1_cell_err_cleared", {56'h0, error}, 64'h0);
        check("op1_cell_writes", 64'(writes), 64'd1);
        lat = 1;

        // Reset while waiting on the write.
        no_resp = 1; writes = 0;
        mem[9] = {8'h03, 28'd1, 28'd42};
        @(posedge clk); #1;
        execute_data = {8'hDE, 28'd7, 28'd9}; execute_tag = 8'hDE; execute_start = 1'b1;
        @(posedge clk); #1;
        execute_start = 1'b0;
        // Read is unanswered here, so feed one manual ready for the read.
        repeat (2) @(posedge clk); #1;
        mem_ready = 1'b1; read_data = mem[9];
        @(posedge clk); #1;
        mem_ready = 1'b0; read_data = 64'h0;
        for (int k = 0; k < 20 && writes == 0; k++) begin @(posedge clk); #1; end
        check("rst_reached_write", 64'(writes), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_outputs", {address, mem_func, mem_execute, execute_finished, error,
                                  execute_return_sys_func, execute_return_state}, 64'h0);
        check("rst_mid_write_data", write_data, 64'h0);
        rst = 1'b0; no_resp = 0;
        mem[9] = {8'h03, 28'd4, 28'd0};
        run(8'hDE, 28'd20, 28'd9, 0);
        check("post_rst_mem5", mem[5], {8'h53, 28'd21, 28'd0});

        // Start held high well past finished: one pulse, one read.
        mem[9] = {8'h03, 28'd1, 28'd42};
        reads = 0; fin_count = 0;
        @(posedge clk); #1;
        execute_data = {8'hDE, 28'd7, 28'd9}; execute_start = 1'b1;
        for (int k = 0; k < 40 && fin_count == 0; k++) begin @(posedge clk); #1; end
        repeat (10) @(posedge clk); #1;
        check("hold_fin_count", 64'(fin_count), 64'd1);
        check("hold_reads", 64'(reads), 64'd1);
        execute_start = 1'b0;
        repeat (3) @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
